// File: rtl/qspi_txn_engine.sv
// qspi_txn_engine: runs QPI-mode read/write bursts on the shared QSPI Pmod
// (CS0 = flash, CS1 = PSRAM) on behalf of mem_ctrl. Each nibble takes two
// clocks: phase 0 drives IO with SCK low, phase 1 raises SCK for the device.
module qspi_txn_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_BITS    = 24,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_BITS:0]    addr_in,
  input  logic                  start_read,
  input  logic                  start_write,
  input  logic                  stall_txn,
  input  logic                  stop_txn,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_ready,
  output logic                  busy,
  output logic                  spi_sck,
  output logic [1:0]            spi_cs_n,
  output logic [3:0]            spi_d_out,
  output logic [3:0]            spi_d_oe,
  input  logic [3:0]            spi_d_in
);

  localparam logic [7:0] CMD_READ   = 8'hEB;
  localparam logic [7:0] CMD_WRITE  = 8'h38;
  localparam logic [7:0] LAST_ADDR  = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0] LAST_DUMMY = 8'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, DESELECT
  } state_t;

  state_t               state;
  logic                 is_read;
  logic [ADDR_BITS-1:0] addr_sr;    // address, consumed MSB nibble first
  logic [3:0]           wr_lo;      // low nibble of the byte being written
  logic [3:0]           rd_hi;      // high nibble of the byte being read
  logic                 phase;      // 0: SCK low / drive, 1: SCK high / sample
  logic [7:0]           cnt;        // nibble (or SCK period) index within a state
  logic                 hold;       // parked at a byte boundary by stall_txn
  logic                 stop_flag;
  logic                 byte_done;
  logic                 at_boundary;
  logic [7:0]           cmd_byte;
  state_t               data_state;

  assign cmd_byte   = is_read ? CMD_READ : CMD_WRITE;
  assign data_state = is_read ? RD_DATA : WR_DATA;

  // Flag the last phase-1 cycle before a byte boundary (or a stalled boundary).
  always_comb begin
    // NOTE: default assigned first so every path writes it and no latch is inferred.
    byte_done = 1'b0;
    if (phase) begin
      case (state)
        ADDR:             byte_done = !is_read && (cnt == LAST_ADDR);
        DUMMY:            byte_done = (cnt == LAST_DUMMY);
        RD_DATA, WR_DATA: byte_done = (cnt == 8'd1);
        default:          byte_done = 1'b0;
      endcase
    end
    at_boundary = hold || byte_done;
  end

  // Transaction FSM with all bus and handshake outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      is_read    <= 1'b0;
      addr_sr    <= '0;
      wr_lo      <= '0;
      rd_hi      <= '0;
      phase      <= 1'b0;
      cnt        <= '0;
      hold       <= 1'b0;
      stop_flag  <= 1'b0;
      data_req   <= 1'b0;
      data_out   <= '0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      spi_sck    <= 1'b0;
      spi_cs_n   <= 2'b11;
      spi_d_out  <= '0;
      spi_d_oe   <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      data_ready <= 1'b0;
      data_req   <= 1'b0;

      if (state == DESELECT)
        stop_flag <= 1'b0;
      else if (state != IDLE && stop_txn)
        stop_flag <= 1'b1;

      // Read capture happens at the end of phase 1, high nibble first.
      if (state == RD_DATA && phase) begin
        if (cnt == 8'd0) begin
          rd_hi <= spi_d_in;
        end else begin
          data_out   <= {rd_hi, spi_d_in};
          data_ready <= 1'b1;
        end
      end

      if (at_boundary) begin
        spi_sck <= 1'b0;
        phase   <= 1'b0;
        if (stop_flag || stop_txn) begin
          state     <= DESELECT;
          hold      <= 1'b0;
          cnt       <= '0;
          spi_cs_n  <= 2'b11;
          spi_d_oe  <= '0;
          spi_d_out <= '0;
        end else if (stall_txn) begin
          state <= data_state;
          hold  <= 1'b1;
        end else begin
          state <= data_state;
          hold  <= 1'b0;
          cnt   <= '0;
          if (is_read) begin
            spi_d_oe  <= '0;
            spi_d_out <= '0;
          end else begin
            wr_lo     <= data_in[3:0];
            data_req  <= 1'b1;
            spi_d_out <= data_in[DATA_WIDTH-1 -: 4];
            spi_d_oe  <= 4'hF;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_read || (start_write && addr_in[ADDR_BITS])) begin
              state     <= CMD;
              is_read   <= start_read;
              addr_sr   <= addr_in[ADDR_BITS-1:0];
              busy      <= 1'b1;
              phase     <= 1'b0;
              cnt       <= '0;
              spi_sck   <= 1'b0;
              spi_cs_n  <= addr_in[ADDR_BITS] ? 2'b01 : 2'b10;
              spi_d_out <= start_read ? CMD_READ[7:4] : CMD_WRITE[7:4];
              spi_d_oe  <= 4'hF;
            end
          end
          DESELECT: begin
            if (cnt == 8'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            if (!phase) begin
              spi_sck <= 1'b1;
              phase   <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              phase   <= 1'b0;
              cnt     <= cnt + 8'd1;
              case (state)
                CMD: begin
                  if (cnt == 8'd0) begin
                    spi_d_out <= cmd_byte[3:0];
                  end else begin
                    state     <= ADDR;
                    cnt       <= '0;
                    spi_d_out <= addr_sr[ADDR_BITS-1 -: 4];
                  end
                end
                ADDR: begin
                  if (cnt == LAST_ADDR) begin
                    // Only reads get here; writes leave ADDR through a byte boundary.
                    state     <= DUMMY;
                    cnt       <= '0;
                    spi_d_oe  <= '0;
                    spi_d_out <= '0;
                  end else begin
                    spi_d_out <= addr_sr[ADDR_BITS-5 -: 4];
                    addr_sr   <= addr_sr << 4;
                  end
                end
                WR_DATA:  spi_d_out <= wr_lo;
                default:  ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_txn_engine.sv
// tb_qspi_txn_engine: randomized bursts against a bus-level model of the
// QSPI transaction engine (nibble sequence, handshake timing, burst length).
module tb_qspi_txn_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [24:0] addr_in = '0;
  logic        start_read = 1'b0;
  logic        start_write = 1'b0;
  logic        stall_txn = 1'b0;
  logic        stop_txn = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_req;
  logic [7:0]  data_out;
  logic        data_ready;
  logic        busy;
  logic        spi_sck;
  logic [1:0]  spi_cs_n;
  logic [3:0]  spi_d_out;
  logic [3:0]  spi_d_oe;
  logic [3:0]  spi_d_in = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0]  payload [8];
  logic [9:0]  got_bus [$];
  logic [31:0] rdy_q [$];
  int          req_q [$];
  logic [1:0]  cs_at [0:199];
  logic        busy_at [0:199];

  qspi_txn_engine dut (
    .clock       (clock),
    .reset       (reset),
    .addr_in     (addr_in),
    .start_read  (start_read),
    .start_write (start_write),
    .stall_txn   (stall_txn),
    .stop_txn    (stop_txn),
    .data_in     (data_in),
    .data_req    (data_req),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .busy        (busy),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_d_out   (spi_d_out),
    .spi_d_oe    (spi_d_oe),
    .spi_d_in    (spi_d_in)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First phase-0 cycle of data byte k, counted from the start-accept cycle.
  function automatic int start_of(input logic rd, input int k, input int s, input int len);
    return (rd ? 29 : 17) + 4 * k + ((k >= s) ? len : 0);
  endfunction

  // Expected {cs_n, oe, nibble} seen at rising SCK edge k of a burst.
  function automatic logic [9:0] exp_edge(input logic rd, input logic [24:0] a, input int k);
    logic [1:0] cs;
    logic [7:0] cmd;
    logic [7:0] b;
    logic [3:0] oe;
    logic [3:0] nib;
    cs  = a[24] ? 2'b01 : 2'b10;
    cmd = rd ? 8'hEB : 8'h38;
    oe  = 4'hF;
    nib = 4'h0;
    if (k < 2) begin
      nib = (k == 0) ? cmd[7:4] : cmd[3:0];
    end else if (k < 8) begin
      nib = 4'(a[23:0] >> (4 * (7 - k)));
    end else if (rd) begin
      oe = 4'h0;
    end else begin
      b   = payload[(k - 8) / 2];
      nib = ((k - 8) % 2 == 0) ? b[7:4] : b[3:0];
    end
    return {cs, oe, nib};
  endfunction

  // One burst: n data bytes, stall of len cycles at the boundary before byte s,
  // stop pulsed so that exactly n bytes transfer.
  task automatic run_txn(input logic rd, input logic wr, input logic [24:0] a,
                         input int n, input int s, input int len);
    logic accepted;
    logic eff_rd;
    logic sck_prev;
    int   stall_d, stop_c, end_c, idle_c, exp_edges, sck_bad, req_cnt, e, j;
    got_bus.delete();
    rdy_q.delete();
    req_q.delete();
    eff_rd   = rd;
    accepted = rd || (wr && a[24]);
    stall_d  = start_of(eff_rd, s, s, 0) - 1;
    stop_c   = (n == 0) ? $urandom_range(4, 1)
                        : start_of(eff_rd, n - 1, s, len) + $urandom_range(3, 0);
    end_c    = start_of(eff_rd, n, s, len);
    exp_edges = 8 + (eff_rd ? 6 : 0) + 2 * n;
    idle_c   = -1;
    sck_bad  = 0;
    req_cnt  = 0;
    sck_prev = 1'b0;

    @(negedge clock);
    addr_in     = a;
    start_read  = rd;
    start_write = wr;
    data_in     = payload[0];
    @(negedge clock);
    start_read  = 1'b0;
    start_write = 1'b0;

    if (!accepted) begin
      repeat (3) begin
        check("ignored_busy", 32'(busy), 32'h0);
        check("ignored_cs", 32'(spi_cs_n), 32'h3);
        @(negedge clock);
      end
      return;
    end

    for (int c = 1; c < 150; c++) begin
      if (c > 1) @(negedge clock);
      busy_at[c] = busy;
      cs_at[c]   = spi_cs_n;
      if (spi_sck && !sck_prev) begin
        if (spi_cs_n == 2'b11) sck_bad++;
        got_bus.push_back({spi_cs_n, spi_d_oe, (spi_d_oe == 4'h0) ? 4'h0 : spi_d_out});
        e = got_bus.size() - 1;
        j = e - 14;
        if (eff_rd && j >= 0 && j < 2 * n)
          spi_d_in = (j % 2 == 0) ? payload[j / 2][7:4] : payload[j / 2][3:0];
        else
          spi_d_in = 4'($urandom);
      end
      sck_prev = spi_sck;
      if (data_ready) rdy_q.push_back({8'h0, 16'(c), data_out});
      if (data_req) begin
        req_q.push_back(c);
        if (req_cnt < 7) req_cnt++;
        data_in = payload[req_cnt];
      end
      stall_txn = (len > 0) && (c >= stall_d) && (c < stall_d + len);
      stop_txn  = (c == stop_c);
      if (!busy) begin
        idle_c = c;
        break;
      end
    end
    stall_txn = 1'b0;
    stop_txn  = 1'b0;

    check("busy_fall_cycle", 32'(idle_c), 32'(end_c + 2));
    if (idle_c == end_c + 2) begin
      check("deselect_cs0", 32'(cs_at[end_c]), 32'h3);
      check("deselect_cs1", 32'(cs_at[end_c + 1]), 32'h3);
      check("deselect_busy", 32'(busy_at[end_c + 1]), 32'h1);
    end
    check("sck_edge_count", 32'(got_bus.size()), 32'(exp_edges));
    for (int k = 0; k < got_bus.size() && k < exp_edges; k++)
      check($sformatf("bus_edge%0d", k), 32'(got_bus[k]), 32'(exp_edge(eff_rd, a, k)));
    check("sck_while_deselected", 32'(sck_bad), 32'h0);
    check("data_ready_count", 32'(rdy_q.size()), 32'(eff_rd ? n : 0));
    for (int k = 0; k < rdy_q.size() && k < n; k++) begin
      check($sformatf("rdy%0d_cycle", k), 32'(rdy_q[k][23:8]), 32'(start_of(eff_rd, k, s, len) + 4));
      check($sformatf("rdy%0d_data", k), 32'(rdy_q[k][7:0]), 32'(payload[k]));
    end
    check("data_req_count", 32'(req_q.size()), 32'(eff_rd ? 0 : n));
    for (int k = 0; k < req_q.size() && k < n; k++)
      check($sformatf("req%0d_cycle", k), 32'(req_q[k]), 32'(start_of(eff_rd, k, s, len)));

    if (idle_c < 0) begin
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic reset_mid_burst();
    int   edges;
    logic prev;
    @(negedge clock);
    addr_in    = 25'h1_ABCDEF;
    start_read = 1'b1;
    @(negedge clock);
    start_read = 1'b0;
    repeat (8) @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_cs", 32'(spi_cs_n), 32'h3);
    check("rst_mid_sck", 32'(spi_sck), 32'h0);
    check("rst_mid_oe", 32'(spi_d_oe), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    edges = 0;
    prev  = spi_sck;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i == 5) reset = 1'b0;
      if (spi_sck && !prev) edges++;
      prev = spi_sck;
    end
    check("rst_no_sck_after", 32'(edges), 32'h0);
    check("rst_idle_cs", 32'(spi_cs_n), 32'h3);
    check("rst_idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    logic        rd, wr;
    logic [24:0] a;
    int          n, s, len;

    #1 reset = 1'b1;
    #1;
    check("reset_cs", 32'(spi_cs_n), 32'h3);
    check("reset_sck", 32'(spi_sck), 32'h0);
    check("reset_oe", 32'(spi_d_oe), 32'h0);
    check("reset_dout", 32'(spi_d_out), 32'h0);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_pulses", 32'({data_ready, data_req}), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Flash read of two bytes.
    payload[0] = 8'h5A; payload[1] = 8'hC3;
    run_txn(1'b1, 1'b0, 25'h0_000010, 2, 0, 0);

    // PSRAM write of two bytes.
    payload[0] = 8'hA5; payload[1] = 8'h3C; payload[2] = 8'h00;
    run_txn(1'b0, 1'b1, 25'h1_001234, 2, 0, 0);

    // Five-cycle stall before the second read byte.
    payload[0] = 8'h11; payload[1] = 8'h96; payload[2] = 8'hE7;
    run_txn(1'b1, 1'b0, 25'h1_FEDCBA, 3, 1, 5);

    // Write to flash is ignored; simultaneous starts resolve to a read.
    run_txn(1'b0, 1'b1, 25'h0_123456, 1, 0, 0);
    payload[0] = 8'h42;
    run_txn(1'b1, 1'b1, 25'h1_0000FF, 1, 0, 0);

    // Stop during CMD: full preamble, zero data bytes.
    run_txn(1'b1, 1'b0, 25'h0_777777, 0, 0, 0);
    run_txn(1'b0, 1'b1, 25'h1_246800, 0, 0, 0);

    reset_mid_burst();
    repeat (2) @(negedge clock);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) payload[i] = 8'($urandom);
      rd  = 1'($urandom_range(1, 0));
      wr  = rd ? 1'($urandom_range(1, 0)) : 1'b1;
      a   = 25'($urandom);
      n   = $urandom_range(4, 0);
      s   = (n > 0) ? $urandom_range(n - 1, 0) : 0;
      len = (n > 0) ? $urandom_range(6, 0) : 0;
      run_txn(rd, wr, a, n, s, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
